// File: rtl/mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : mux_n_pipe
// Description : N-way WIDTH-bit select multiplexer feeding a registered
//               ready/valid output stage with a two-entry skid buffer.
//               Out-of-range selects fall through to the last input and
//               raise a sticky-per-beat select error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module mux_n_pipe #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_sel_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    // One extra bit so NUM_IN itself is representable when it is a power of two
    localparam logic [SEL_W:0] c_num_in = (SEL_W+1)'(NUM_IN);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [WIDTH-1:0] r_main_data;
    logic [SEL_W-1:0] r_main_sel;
    logic             r_main_err;
    logic [WIDTH-1:0] r_skid_data;
    logic [SEL_W-1:0] r_skid_sel;
    logic             r_skid_err;

    logic [WIDTH-1:0] w_mux_data;
    logic             w_mux_err;
    logic             w_accept;
    logic             w_consume;
    logic             w_load_main_in;
    logic             w_load_main_skid;
    logic             w_load_skid;

    // Both valid bits come straight from the state register, so in_ready
    // never sees out_ready combinationally.
    assign out_valid   = (r_state != ST_EMPTY);
    assign in_ready    = (r_state != ST_FULL);
    assign out_data    = r_main_data;
    assign out_sel     = r_main_sel;
    assign out_sel_err = r_main_err;

    assign w_accept  = in_valid && in_ready && !flush;
    assign w_consume = out_valid && out_ready;

    // Select mux: default to the last input, override on an in-range match
    always_comb begin
        w_mux_data = in_data[(NUM_IN-1)*WIDTH +: WIDTH];
        w_mux_err  = !({1'b0, in_sel} < c_num_in);
        for (int k = 0; k < NUM_IN - 1; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_mux_data = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Next state and register load enables; flush kills every held beat
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_load_main_in = 1'b1;
                        w_state_nxt    = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        w_load_skid = 1'b1;
                        w_state_nxt = ST_FULL;
                    end else if (w_consume) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (w_consume) begin
                        w_load_main_skid = 1'b1;
                        w_state_nxt      = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main and skid data registers; contents persist across a flush
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main_data <= '0;
            r_main_sel  <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_sel  <= '0;
            r_skid_err  <= 1'b0;
        end else begin
            if (w_load_main_in) begin
                r_main_data <= w_mux_data;
                r_main_sel  <= in_sel;
                r_main_err  <= w_mux_err;
            end else if (w_load_main_skid) begin
                r_main_data <= r_skid_data;
                r_main_sel  <= r_skid_sel;
                r_main_err  <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_data <= w_mux_data;
                r_skid_sel  <= in_sel;
                r_skid_err  <= w_mux_err;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_n_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_mux_n_pipe
// Description : Scoreboard bench for mux_n_pipe (4-input and 3-input builds)
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mux_n_pipe;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  sel;
        logic        err;
    } beat_t;

    logic         clk;
    logic         reset;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic         flush;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;
    logic         out_sel_err;
    logic         out_valid;
    logic         out_ready;

    logic [95:0]  d3;
    logic [1:0]   sel3;
    logic         v3;
    logic         rdy3;
    logic [31:0]  out_data3;
    logic [1:0]   out_sel3;
    logic         err3;
    logic         ov3;

    beat_t q[$];
    beat_t q3[$];
    beat_t exp_next;
    beat_t exp3;
    logic  mon_en;
    logic  last_acc;
    int    n_checks;
    int    n_errs;

    mux_n_pipe #(.WIDTH(32), .NUM_IN(4)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_sel_err(out_sel_err),
        .out_valid(out_valid), .out_ready(out_ready)
    );

    mux_n_pipe #(.WIDTH(32), .NUM_IN(3)) dut3 (
        .clk(clk), .reset(reset), .in_data(d3), .in_sel(sel3),
        .in_valid(v3), .in_ready(rdy3), .flush(1'b0),
        .out_data(out_data3), .out_sel(out_sel3), .out_sel_err(err3),
        .out_valid(ov3), .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic beat_t model4(logic [127:0] d, logic [1:0] s);
        beat_t b;
        int    idx;
        idx    = int'(s) * 32;
        b.data = d[idx +: 32];
        b.sel  = s;
        b.err  = 1'b0;
        return b;
    endfunction

    // Monitor: compare the head beat every cycle it is presented, pop on consume
    always @(negedge clk) begin
        if (mon_en) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() > 0 && out_valid) begin
                chk("head_data", out_data, q[0].data);
                chk("head_sel", 32'(out_sel), 32'(q[0].sel));
                chk("head_err", 32'(out_sel_err), 32'(q[0].err));
                if (out_ready) q.pop_front();
            end
        end
    end

    // Monitor for the 3-input build (always ready downstream)
    always @(negedge clk) begin
        if (mon_en) begin
            chk("d3_valid", 32'(ov3), 32'(q3.size() > 0));
            if (q3.size() > 0 && ov3) begin
                chk("d3_data", out_data3, q3[0].data);
                chk("d3_sel", 32'(out_sel3), 32'(q3[0].sel));
                chk("d3_err", 32'(err3), 32'(q3[0].err));
                q3.pop_front();
            end
        end
    end

    // One clock: record what the coming edge accepts, return at posedge+1
    task automatic tick();
        @(negedge clk);
        #2;
        last_acc = 1'b0;
        if (reset || flush) begin
            q.delete();
        end else if (in_valid && in_ready) begin
            q.push_back(exp_next);
            last_acc = 1'b1;
        end
        if (reset) q3.delete();
        else if (v3 && rdy3) q3.push_back(exp3);
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic [31:0] w);
        in_data  = {96'h0, w};
        in_sel   = 2'd0;
        in_valid = 1'b1;
        exp_next = '{data: w, sel: 2'd0, err: 1'b0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errs = 0; mon_en = 1'b0; last_acc = 1'b0;
        reset = 1'b1; in_data = '0; in_sel = '0; in_valid = 1'b0;
        flush = 1'b0; out_ready = 1'b0;
        d3 = '0; sel3 = '0; v3 = 1'b0;
        exp_next = '{data: 32'h0, sel: 2'd0, err: 1'b0};
        exp3     = '{data: 32'h0, sel: 2'd0, err: 1'b0};
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_sel", 32'(out_sel), 32'd0);
        chk("rst_out_err", 32'(out_sel_err), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic select, full throughput
        in_data   = {32'h0D, 32'h0C, 32'h0B, 32'h0A};
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_sel   = 2'(i);
            exp_next = '{data: 32'h0A + 32'(i), sel: 2'(i), err: 1'b0};
            tick();
        end
        in_valid = 1'b0;
        tick(); tick();

        // Out-of-range select on the 3-input build
        d3   = {32'h3, 32'h2, 32'h1};
        v3   = 1'b1;
        sel3 = 2'd3;
        exp3 = '{data: 32'h3, sel: 2'd3, err: 1'b1};
        tick();
        sel3 = 2'd1;
        exp3 = '{data: 32'h2, sel: 2'd1, err: 1'b0};
        tick();
        v3 = 1'b0;
        tick(); tick();

        // Backpressure into the skid buffer
        out_ready = 1'b0;
        put(32'hA000_0001); tick();
        put(32'hB000_0002); tick();
        put(32'hC000_0003); tick();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_a", out_data, 32'hA000_0001);
        tick(); tick();
        chk("bp_c_stalled", 32'(last_acc), 32'd0);
        out_ready = 1'b1;
        begin
            int n;
            n = 0;
            while (!last_acc && n < 10) begin
                tick();
                n++;
            end
            chk("bp_c_accepted", 32'(last_acc), 32'd1);
        end
        in_valid = 1'b0;
        tick(); tick(); tick();

        // Flush from FULL with a concurrent input beat
        out_ready = 1'b0;
        put(32'hA111_0001); tick();
        put(32'hB111_0002); tick();
        put(32'hC111_0003);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        chk("flush_keep_data", out_data, 32'hA111_0001);
        out_ready = 1'b1;
        tick(); tick();

        // Reset while holding one beat
        out_ready = 1'b0;
        put(32'hA222_0001); tick();
        reset = 1'b1;
        put(32'hEEEE_EEEE);
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_data", out_data, 32'd0);
        chk("mid_rst_ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        put(32'hD222_0004); tick();
        in_valid = 1'b0;
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        chk("post_rst_data", out_data, 32'hD222_0004);
        tick();

        // Random stress against the reference queue
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 9) == 0);
            exp_next  = model4(in_data, in_sel);
            tick();
        end
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();
        chk("drain_empty", 32'(q.size()), 32'd0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_n_pipe.md
# mux_n_pipe

Parametrised N-way, WIDTH-bit select multiplexer with a registered, ready/valid-handshaked output stage and a two-entry skid buffer. It is the successor of the fixed 5-bit 4:1 select mux. It is used in the RISC datapath wherever a selected operand or writeback value must cross a pipeline boundary with backpressure, stall and flush. Selection follows the same fall-through rule as the 4:1 mux: any select value outside the valid range picks the last input.

## Interface
- WIDTH, 32, data width of each input and of the output
- NUM_IN, 4, number of inputs (2..16)
- SEL_W, $clog2(NUM_IN), select width (derived; do not override)

One clock; reset is synchronous and active-high.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH]
- in_sel  input  SEL_W  binary select
- in_valid  input  1  upstream offers a beat
- in_ready  output  1  block can accept a beat; equals !skid_valid (register-derived)
- flush  input  1  discard all held beats (pipeline kill)
- out_data  output  WIDTH  selected data of the head beat
- out_sel  output  SEL_W  select value as presented, unclamped
- out_sel_err  output  1  head beat had in_sel >= NUM_IN
- out_valid  output  1  head beat valid
- out_ready  input  1  downstream consumes the head beat

## Operation
- Accept: in_valid && in_ready && !flush. Consume: out_valid && out_ready.
- Mux: the accepted word is in_data[in_sel] when in_sel < NUM_IN; otherwise it is input NUM_IN-1 and sel_err=1. The mux is combinational ahead of the capture registers.
- Storage: main register (drives the out_* ports) and skid register, each with its own valid bit.
- State and transitions (flush=0):
  - EMPTY to ONE on accept.
  - ONE with accept and consume: main reloads from the input; stays ONE.
  - ONE with accept and no consume: the beat goes to skid; to FULL.
  - ONE with consume and no accept: to EMPTY.
  - FULL with consume: skid moves to main; to ONE. Accept is impossible in FULL because in_ready=0.
  - FULL with no consume: holds.
- flush=1: both valid bits clear next cycle and the input beat is not accepted, whatever in_valid or out_ready are doing. out_data, out_sel and out_sel_err keep their last values; consumers qualify them with out_valid.
- reset overrides flush.
- Ordering is strictly FIFO; beats are never duplicated or dropped except by flush or reset.
- While out_valid=1 && out_ready=0, out_data, out_sel and out_sel_err are stable.

## Timing
- Latency: a beat accepted at edge n appears on out_* with out_valid=1 after edge n; it is visible in the cycle following acceptance.
- Throughput: one beat per cycle sustained while out_ready=1.
- in_ready depends only on registers, with no combinational path from out_ready. This keeps long stall chains from forming timing loops.
- Reset values: out_valid=0, out_data=0, out_sel=0, out_sel_err=0, skid_valid=0, therefore in_ready=1 in the first cycle after reset.
- Inputs sampled in a cycle with reset=1 are ignored.
- Reset mid-transfer, in ONE or FULL: all held beats are lost and the block is in EMPTY after the edge.
- Flush in the same cycle as a consume: the consumed beat counts as delivered. The remaining beats are discarded.

## Test plan
- Basic select: WIDTH=32, NUM_IN=4, out_ready=1, inputs {0x0A,0x0B,0x0C,0x0D}, in_sel 0,1,2,3 on consecutive cycles -> out_data 0x0A,0x0B,0x0C,0x0D one cycle later, out_valid continuous, in_ready stays 1.
- Out-of-range select: NUM_IN=3, inputs {0x1,0x2,0x3}, in_sel=3 -> out_data=0x3, out_sel=3, out_sel_err=1; the following in_sel=1 -> 0x2, out_sel_err=0.
- Backpressure and skid: send beats A, B, C back-to-back with out_ready=0 from the cycle A appears. Required response:
  - A is held on out_*.
  - B goes to skid and in_ready drops to 0; C is stalled upstream.
  - When out_ready is raised: A, then B, then C, with no gaps or duplicates.
- Flush: FULL with A and B, out_ready=0, pulse flush for one cycle together with in_valid=1 carrying C -> out_valid=0 and in_ready=1 the next cycle; C is not delivered.
- Reset mid-operation: in state ONE, assert reset for one cycle with in_valid=1 -> out_valid=0, out_data=0, in_ready=1 after the edge; the next accepted beat appears normally one cycle later.
- Random stress: random in_valid, out_ready and flush at 10%, compared against a reference queue model -> in-order delivery, no loss except flushed beats, and out_* stable under stall.
